// File: rtl/out_port_tx_if.sv
// Transmit handshake bundle between out_port_tx (master) and the external device (slave).
// A word moves on every rising edge where tx_valid and tx_ready are both 1; the master holds tx_data stable while tx_ready is 0.
interface out_port_tx_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/out_port_tx.sv
// miniSRC output port: CPU "out Ra" writes are queued in a small FIFO and sent over a valid/ready link,
// with an optional idle gap after every completed transfer.
module out_port_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int GAP    = 0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                outPort_en,
  input  logic [DATA_W-1:0]   busData,
  input  logic                ovf_clr,
  output logic [DATA_W-1:0]   outPortData,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic [1:0]          state_dbg,
  out_port_tx_if.master       tx
);

  localparam int             CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          gap_cnt;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_valid_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                en_d;

  logic                wr;
  logic                pop;
  logic                push;
  logic                drop;
  logic [CNT_W-1:0]    count_nxt;

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign state_dbg   = state;

  // One write per strobe: rising edge of the level-held enable.
  assign wr   = outPort_en & ~en_d;
  assign pop  = !empty && ((state == ST_IDLE) ||
                           (state == ST_SEND && tx.tx_ready && (GAP == 0)));
  assign push = wr && (!full || pop);
  assign drop = wr && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      en_d        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      outPortData <= '0;
    end else begin
      en_d  <= outPort_en;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      if (wr)   outPortData <= busData;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A fresh drop on the clearing edge keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // When full, push and pop share a slot; the pop reads the old head before it is overwritten.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= busData;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            tx_data_q  <= mem[rd_ptr];
            tx_valid_q <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx.tx_ready) begin
            if (GAP == 0) begin
              if (!empty) begin
                tx_data_q <= mem[rd_ptr];
              end else begin
                tx_valid_q <= 1'b0;
                state      <= ST_IDLE;
              end
            end else begin
              gap_cnt    <= GAP_LOAD;
              tx_valid_q <= 1'b0;
              state      <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state   <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          tx_valid_q <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_tx.sv
// Directed bench for out_port_tx: a GAP=0 instance for queueing/overflow/reset and a GAP=2 instance for the idle gap.
module tb_out_port_tx;
  logic        clock;
  logic        clear;

  logic        en1, ovf_clr1;
  logic [31:0] bus1, out_data1;
  logic [2:0]  count1;
  logic        full1, empty1, ovf1;
  logic [1:0]  st1;

  logic        en2, ovf_clr2;
  logic [31:0] bus2, out_data2;
  logic [2:0]  count2;
  logic        full2, empty2, ovf2;
  logic [1:0]  st2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  out_port_tx_if #(.DATA_W(32)) if1 ();
  out_port_tx_if #(.DATA_W(32)) if2 ();

  out_port_tx #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .GAP(0)) dut1 (
    .clock(clock), .clear(clear), .outPort_en(en1), .busData(bus1), .ovf_clr(ovf_clr1),
    .outPortData(out_data1), .count(count1), .full(full1), .empty(empty1),
    .overflow(ovf1), .state_dbg(st1), .tx(if1.master)
  );

  out_port_tx #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .GAP(2)) dut2 (
    .clock(clock), .clear(clear), .outPort_en(en2), .busData(bus2), .ovf_clr(ovf_clr2),
    .outPortData(out_data2), .count(count2), .full(full2), .empty(empty2),
    .overflow(ovf2), .state_dbg(st2), .tx(if2.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write1(input logic [31:0] d);
    en1 = 1'b1; bus1 = d;
    tick();
    en1 = 1'b0;
    tick();
  endtask

  task automatic write2(input logic [31:0] d);
    en2 = 1'b1; bus2 = d;
    tick();
    en2 = 1'b0;
    tick();
  endtask

  initial begin
    clear = 1'b0;
    en1 = 1'b0; bus1 = '0; ovf_clr1 = 1'b0; if1.tx_ready = 1'b0;
    en2 = 1'b0; bus2 = '0; ovf_clr2 = 1'b0; if2.tx_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_data", out_data1, 32'h0);
    check("rst_tx_data", if1.tx_data, 32'h0);
    check("rst_tx_valid", {31'b0, if1.tx_valid}, 32'd0);
    check("rst_count", {29'b0, count1}, 32'd0);
    check("rst_empty", {31'b0, empty1}, 32'd1);
    check("rst_full", {31'b0, full1}, 32'd0);
    check("rst_overflow", {31'b0, ovf1}, 32'd0);
    check("rst_state", {30'b0, st1}, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    tick();

    // 1: single write, enable held 3 cycles, sink always ready
    en1 = 1'b1; bus1 = 32'h20; if1.tx_ready = 1'b1;
    tick();
    check("t1_e0_count", {29'b0, count1}, 32'd1);
    check("t1_e0_valid", {31'b0, if1.tx_valid}, 32'd0);
    check("t1_e0_out_data", out_data1, 32'h20);
    tick();
    check("t1_e1_valid", {31'b0, if1.tx_valid}, 32'd1);
    check("t1_e1_data", if1.tx_data, 32'h20);
    check("t1_e1_count", {29'b0, count1}, 32'd0);
    tick();
    check("t1_e2_valid", {31'b0, if1.tx_valid}, 32'd0);
    en1 = 1'b0;
    tick();
    check("t1_e3_valid", {31'b0, if1.tx_valid}, 32'd0);
    check("t1_e3_count", {29'b0, count1}, 32'd0);

    // 2: stalled sink, five writes fill the link register plus four FIFO slots
    if1.tx_ready = 1'b0;
    write1(32'h1);
    check("t2_head_valid", {31'b0, if1.tx_valid}, 32'd1);
    check("t2_head_data", if1.tx_data, 32'h1);
    for (int i = 2; i <= 5; i++) begin
      write1(32'(i));
      exp_q.push_back(32'(i));
    end
    check("t2_count", {29'b0, count1}, 32'd4);
    check("t2_full", {31'b0, full1}, 32'd1);
    check("t2_empty", {31'b0, empty1}, 32'd0);
    check("t2_data_held", if1.tx_data, 32'h1);
    check("t2_overflow", {31'b0, ovf1}, 32'd0);

    // 3: drop on full, drop wins over a same-edge clear, then clear
    write1(32'h6);
    check("t3_overflow", {31'b0, ovf1}, 32'd1);
    check("t3_out_data", out_data1, 32'h6);
    check("t3_count", {29'b0, count1}, 32'd4);
    en1 = 1'b1; bus1 = 32'h66; ovf_clr1 = 1'b1;
    tick();
    check("t3_drop_wins", {31'b0, ovf1}, 32'd1);
    check("t3_out_data2", out_data1, 32'h66);
    en1 = 1'b0;
    tick();
    check("t3_ovf_cleared", {31'b0, ovf1}, 32'd0);
    ovf_clr1 = 1'b0;

    // 4: push accepted on full because the same edge pops; then back-to-back drain
    en1 = 1'b1; bus1 = 32'h7; if1.tx_ready = 1'b1;
    exp_q.push_back(32'h7);
    tick();
    en1 = 1'b0;
    check("t4_data", if1.tx_data, exp_q.pop_front());
    check("t4_count", {29'b0, count1}, 32'd4);
    check("t4_full", {31'b0, full1}, 32'd1);
    check("t4_overflow", {31'b0, ovf1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_drain_valid", {31'b0, if1.tx_valid}, 32'd1);
      check("t4_drain_data", if1.tx_data, exp_q.pop_front());
      check("t4_drain_count", {29'b0, count1}, 32'(3 - i));
    end
    tick();
    check("t4_done_valid", {31'b0, if1.tx_valid}, 32'd0);
    check("t4_done_empty", {31'b0, empty1}, 32'd1);

    // 5: GAP=2 instance, two words
    write2(32'hA);
    write2(32'hB);
    check("t5_a_valid", {31'b0, if2.tx_valid}, 32'd1);
    check("t5_a_data", if2.tx_data, 32'hA);
    check("t5_count", {29'b0, count2}, 32'd1);
    if2.tx_ready = 1'b1;
    tick();
    check("t5_gap1_valid", {31'b0, if2.tx_valid}, 32'd0);
    check("t5_gap1_state", {30'b0, st2}, 32'd2);
    tick();
    check("t5_gap2_valid", {31'b0, if2.tx_valid}, 32'd0);
    check("t5_gap2_state", {30'b0, st2}, 32'd2);
    tick();
    check("t5_idle_valid", {31'b0, if2.tx_valid}, 32'd0);
    check("t5_idle_state", {30'b0, st2}, 32'd0);
    tick();
    check("t5_b_valid", {31'b0, if2.tx_valid}, 32'd1);
    check("t5_b_data", if2.tx_data, 32'hB);
    check("t5_b_count", {29'b0, count2}, 32'd0);
    tick();
    check("t5_b_done", {31'b0, if2.tx_valid}, 32'd0);
    if2.tx_ready = 1'b0;

    // 6: async reset in the middle of a stalled transfer
    if1.tx_ready = 1'b0;
    write1(32'h11);
    write1(32'h12);
    check("t6_pre_valid", {31'b0, if1.tx_valid}, 32'd1);
    check("t6_pre_count", {29'b0, count1}, 32'd1);
    #3;
    clear = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, if1.tx_valid}, 32'd0);
    check("t6_rst_count", {29'b0, count1}, 32'd0);
    check("t6_rst_empty", {31'b0, empty1}, 32'd1);
    check("t6_rst_data", if1.tx_data, 32'h0);
    check("t6_rst_out_data", out_data1, 32'h0);
    #2;
    clear = 1'b1;
    if1.tx_ready = 1'b1;
    write1(32'h9);
    check("t6_new_valid", {31'b0, if1.tx_valid}, 32'd1);
    check("t6_new_data", if1.tx_data, 32'h9);
    tick();
    check("t6_new_done", {31'b0, if1.tx_valid}, 32'd0);
    check("t6_new_count", {29'b0, count1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
